clk_div_prog: RTL

- Multi-channel programmable clock/tick generator; the next generation of the fixed single-divisor divider.
- Each channel divides clk_in by a runtime-loadable divisor. Each channel produces a near-50% divided level (clk_out) and a one-cycle strobe (tick) per period.
- Divisor updates are glitch-free and are applied only at a period boundary.
- Sits between the board clock and the FSM/display logic, which consume the ticks as clock enables.

---
 rtl/clk_div_pkg.sv | 18 +
 rtl/clk_div_chan.sv | 105 ++++++++++
 rtl/clk_div_prog.sv | 59 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults, clog2 helper and channel-state encoding
package clk_div_pkg;

  localparam int WIDTH_DEF       = 27;
  localparam int DEFAULT_DIV_DEF = 100_000_000;

  localparam logic [1:0] ST_HALT = 2'd0;  // D == 0
  localparam logic [1:0] ST_PASS = 2'd1;  // D == 1
  localparam logic [1:0] ST_RUN  = 2'd2;  // D >= 2

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, active/pending divisor, clk_out/tick
// sync_in port exists only when CLKDIV_SYNC_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             pend_full,
  output logic             clk_out,
  output logic             tick
);

  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] d_act, d_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             full_n, clk_n, tick_n;
  logic [1:0]       st;
  logic             wrap;

  assign st   = (d_act == '0) ? ST_HALT : (d_act == WIDTH'(1)) ? ST_PASS : ST_RUN;
  assign wrap = en && (st == ST_RUN) && (count == d_act - WIDTH'(1));

  always_comb begin
    count_n = count;
    clk_n   = clk_out;
    tick_n  = 1'b0;
    d_n     = d_act;
    pend_n  = pend;
    full_n  = pend_full;
    case (st)
      ST_HALT: begin
        count_n = '0;
        clk_n   = 1'b0;
      end
      ST_PASS: begin
        count_n = '0;
        if (en) begin
          clk_n  = 1'b1;
          tick_n = 1'b1;
        end
      end
      default: begin
        if (en) begin
          if (wrap) begin
            count_n = '0;
            tick_n  = 1'b1;
          end else begin
            count_n = count + WIDTH'(1);
          end
          // level is registered against the count it will sit at next cycle
          clk_n = (count_n >= d_act - (d_act >> 1));
        end
      end
    endcase
    // a stopped or pass-through channel has no period boundary to wait for
    if (pend_full && (wrap || st != ST_RUN)) begin
      d_n     = pend;
      full_n  = 1'b0;
      count_n = '0;
    end
`ifdef CLKDIV_SYNC_EN
    if (sync_in) begin
      count_n = '0;
      clk_n   = 1'b0;
      tick_n  = 1'b0;
      if (pend_full) begin
        d_n    = pend;
        full_n = 1'b0;
      end
    end
`endif
    if (wr_en && !pend_full) begin
      pend_n = wr_data;
      full_n = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      d_act     <= WIDTH'(DEFAULT_DIV);
      pend      <= '0;
      pend_full <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      count     <= count_n;
      d_act     <= d_n;
      pend      <= pend_n;
      pend_full <= full_n;
      clk_out   <= clk_n;
      tick      <= tick_n;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - multi-channel programmable clock/tick generator
// Optional CLKDIV_SYNC_EN adds sync_in to phase-align all channels.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter  int CHANNELS    = 2,
  parameter  int WIDTH       = WIDTH_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int SEL_W       = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                div_valid,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [WIDTH-1:0]    div_data,
  output logic                div_ready,
`ifdef CLKDIV_SYNC_EN
  input  logic                sync_in,
`endif
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  logic [CHANNELS-1:0] pend_full;
  logic [CHANNELS-1:0] wr_sel;

  // out-of-range selects match no channel, so ready stays low and the write drops
  always_comb begin
    div_ready = 1'b0;
    wr_sel    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (div_sel == SEL_W'(c)) begin
        div_ready = !pend_full[c];
        wr_sel[c] = div_valid;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .en        (en[g]),
      .wr_en     (wr_sel[g]),
      .wr_data   (div_data),
`ifdef CLKDIV_SYNC_EN
      .sync_in   (sync_in),
`endif
      .pend_full (pend_full[g]),
      .clk_out   (clk_out[g]),
      .tick      (tick[g])
    );
  end

endmodule
